// File: rtl/sd_pwm_multi.sv
// -----------------------------------------------------------------------------
// sd_pwm_multi
//
// Multi-channel sigma-delta bitstream to PWM re-modulator.
//
// Each of NCH 1-bit sigma-delta streams is density-counted over a shared window
// of PERIOD enabled cycles. At the end of a window the count becomes that
// channel's duty word. The duty word then drives a PWM waveform over the
// following window, left- or right-aligned. The latched duty words and a
// one-cycle update strobe are exported for monitoring.
//
// Ports
//   clk         in   1        system clock, rising edge
//   rst_n       in   1        asynchronous active-low reset
//   en          in   1        count enable; low freezes all window state
//   align_mode  in   1        0 = left-aligned, 1 = right-aligned PWM;
//                             taken into use only at a window boundary
//   sd_bs       in   NCH      sigma-delta bitstreams, bit i = channel i
//   pwm_out     out  NCH      registered PWM outputs, bit i = channel i
//   duty        out  NCH*CW   latched duty words, channel i at [i*CW +: CW]
//   duty_valid  out  1        one-cycle strobe, high after the edge that
//                             updated duty
//
// Handshake: duty_valid is a pure strobe with no ready/back-pressure. It is
// high for exactly one cycle after each enabled boundary edge, and duty is
// stable and valid during that cycle. duty then holds until the next strobe,
// so a consumer may also sample it at any later time.
//
// Timing
//   - The shared phase counter runs 0..PERIOD-1 on enabled cycles only. Every
//     window is therefore exactly PERIOD enabled samples long, however many
//     disabled cycles interrupt it.
//   - The boundary sample (phase PERIOD-1) is included in the duty it
//     produces.
//   - The PWM compare is registered. pwm_out reflects the phase, duty and
//     mode values from before the edge, so the output trails the measured
//     window by one window plus one cycle.
// -----------------------------------------------------------------------------
module sd_pwm_multi #(
  parameter  int NCH    = 4,
  parameter  int PERIOD = 60,
  localparam int CW     = $clog2(PERIOD + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              align_mode,
  input  logic [NCH-1:0]    sd_bs,
  output logic [NCH-1:0]    pwm_out,
  output logic [NCH*CW-1:0] duty,
  output logic              duty_valid
);

  // Phase only has to hold 0..PERIOD-1, which can be one bit narrower than CW.
  localparam int             PW     = $clog2(PERIOD);
  localparam logic [PW-1:0]  LAST   = PW'(PERIOD - 1);
  localparam logic [CW-1:0]  PER_CW = CW'(PERIOD);

  // ---------------------------------------------------------------------------
  // Shared window phase
  // ---------------------------------------------------------------------------
  logic [PW-1:0] r_phase;
  logic          w_boundary;
  logic          w_latch;
  logic [CW-1:0] w_phase_cw;

  assign w_boundary = (r_phase == LAST);
  // The boundary only takes effect on an enabled edge. With en low the counter
  // simply waits at PERIOD-1 until the next enabled cycle.
  assign w_latch    = en && w_boundary;
  assign w_phase_cw = CW'(r_phase);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
    end else if (en) begin
      r_phase <= w_boundary ? '0 : r_phase + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Latched alignment mode and window strobe
  // ---------------------------------------------------------------------------
  logic r_mode;
  logic r_dv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= 1'b0;
      r_dv   <= 1'b0;
    end else begin
      if (w_latch) begin
        r_mode <= align_mode;
      end
      r_dv <= w_latch;
    end
  end

  assign duty_valid = r_dv;

  // ---------------------------------------------------------------------------
  // Per-channel density counter, duty latch and PWM compare
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] w_hi;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] r_sum;
    logic [CW-1:0] r_duty;
    logic [CW-1:0] w_sum_next;
    logic          w_hi_left;
    logic          w_hi_right;

    // The sum can reach at most PERIOD (all ones, boundary sample included),
    // and CW holds 0..PERIOD, so no saturation is needed.
    assign w_sum_next = r_sum + CW'(sd_bs[i]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sum  <= '0;
        r_duty <= '0;
      end else if (en) begin
        if (w_boundary) begin
          r_duty <= w_sum_next;
          r_sum  <= '0;
        end else begin
          r_sum  <= w_sum_next;
        end
      end
    end

    // Left: high for phases [0, duty). Right: high for phases
    // [PERIOD-duty, PERIOD). Both give exactly duty high cycles per window.
    // duty = 0 gives a constant low output and duty = PERIOD a constant high.
    // PERIOD - duty cannot underflow because duty <= PERIOD.
    assign w_hi_left  = (w_phase_cw <  r_duty);
    assign w_hi_right = (w_phase_cw >= (PER_CW - r_duty));
    assign w_hi[i]    = r_mode ? w_hi_right : w_hi_left;

    assign duty[i*CW +: CW] = r_duty;
  end

  // ---------------------------------------------------------------------------
  // Registered PWM outputs; forced low while disabled
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] r_pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= en ? w_hi : '0;
    end
  end

  assign pwm_out = r_pwm;

endmodule

// File: tb/tb_sd_pwm_multi.sv
// -----------------------------------------------------------------------------
// tb_sd_pwm_multi
//
// Self-checking bench for sd_pwm_multi with NCH=4 and PERIOD=8.
//
// The reference model works from the externally visible rules. The samples
// of the current window are kept in a queue, and the window closes once
// PERIOD enabled samples are in it. The expected duty for each channel is the
// number of ones that channel received in the closed window. The expected PWM
// level for each cycle follows from the position of that cycle's sample in
// the window, the duty of the previous window and the alignment in force.
//
// The driver pushes per-cycle expectations, and a separate monitor pops and
// compares them after each rising edge.
// -----------------------------------------------------------------------------
module tb_sd_pwm_multi;

  localparam int NCH    = 4;
  localparam int PERIOD = 8;
  localparam int CW     = $clog2(PERIOD + 1);
  localparam int DW     = NCH * CW;

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          align_mode;
  logic [NCH-1:0] sd_bs;
  logic [NCH-1:0] pwm_out;
  logic [DW-1:0]  duty;
  logic           duty_valid;

  always #5 clk = ~clk;

  sd_pwm_multi #(.NCH(NCH), .PERIOD(PERIOD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .align_mode (align_mode),
    .sd_bs      (sd_bs),
    .pwm_out    (pwm_out),
    .duty       (duty),
    .duty_valid (duty_valid)
  );

  // ---------------------------------------------------------------- scoreboard
  typedef struct packed {
    logic [NCH-1:0] pwm;
    logic           dv;
  } cyc_exp_t;

  cyc_exp_t       cyc_q[$];   // per-cycle pwm/strobe expectations
  logic [DW-1:0]  exp_q[$];   // expected duty word per strobe
  int             total = 0;
  int             bad   = 0;

  // Reference model state
  logic [NCH-1:0] win_q[$];   // samples collected in the current window
  int             cur_duty[NCH];
  logic           cur_mode;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    win_q.delete();
    for (int c = 0; c < NCH; c++) cur_duty[c] = 0;
    cur_mode = 1'b0;
  endtask

  // Expectation for the edge that follows inputs (e, bs, m).
  task automatic model_step(input logic e, input logic [NCH-1:0] bs, input logic m);
    cyc_exp_t      x;
    logic [DW-1:0] w;
    int            k;
    int            cnt;
    k    = win_q.size();
    x.dv = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (!e)            x.pwm[c] = 1'b0;
      else if (cur_mode) x.pwm[c] = (k >= PERIOD - cur_duty[c]);
      else               x.pwm[c] = (k <  cur_duty[c]);
    end
    if (e) begin
      win_q.push_back(bs);
      if (win_q.size() == PERIOD) begin
        w = '0;
        for (int c = 0; c < NCH; c++) begin
          cnt = 0;
          foreach (win_q[j]) cnt += int'(win_q[j][c]);
          cur_duty[c]    = cnt;
          w[c*CW +: CW]  = CW'(cnt);
        end
        exp_q.push_back(w);
        cur_mode = m;
        x.dv     = 1'b1;
        win_q.delete();
      end
    end
    cyc_q.push_back(x);
  endtask

  // ---------------------------------------------------------------- driver
  task automatic drive_now(input logic e, input logic [NCH-1:0] bs, input logic m);
    en         = e;
    sd_bs      = bs;
    align_mode = m;
    model_step(e, bs, m);
  endtask

  task automatic drive(input logic e, input logic [NCH-1:0] bs, input logic m);
    @(negedge clk);
    drive_now(e, bs, m);
  endtask

  // Test-plan pattern: ch0 constant 1, ch1 alternating from phase 0,
  // ch2 high on the last phase only, ch3 random.
  function automatic logic [NCH-1:0] pat(input int k);
    logic [NCH-1:0] p;
    p[0] = 1'b1;
    p[1] = (k % 2 == 0);
    p[2] = (k == PERIOD - 1);
    p[3] = 1'($urandom_range(0, 1));
    return p;
  endfunction

  task automatic run_until_k(input int target, input logic m);
    int guard;
    guard = 0;
    while (win_q.size() != target && guard < 4 * PERIOD) begin
      drive(1'b1, pat(win_q.size()), m);
      guard++;
    end
  endtask

  // ---------------------------------------------------------------- monitor
  always @(posedge clk) begin
    cyc_exp_t e;
    #1;
    if (rst_n === 1'b1 && cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      chk("pwm_out", 64'(pwm_out), 64'(e.pwm));
      chk("duty_valid", 64'(duty_valid), 64'(e.dv));
      if (duty_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL duty_unexpected got=%0h exp=none t=%0t", duty, $time);
        end else begin
          chk("duty", 64'(duty), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic m;
    rst_n      = 1'b1;
    en         = 1'b0;
    align_mode = 1'b0;
    sd_bs      = '0;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive_now(1'b1, '0, 1'b0);
    #1;
    chk("reset_duty", 64'(duty), 64'd0);
    chk("reset_pwm", 64'(pwm_out), 64'd0);
    chk("reset_dv", 64'(duty_valid), 64'd0);

    // Idle: all-zero streams, strobe every PERIOD cycles
    repeat (31) drive(1'b1, '0, 1'b0);

    // Extremes and density, left-aligned
    repeat (3 * PERIOD) drive(1'b1, pat(win_q.size()), 1'b0);

    // Right alignment requested mid-window
    run_until_k(4, 1'b0);
    repeat (3 * PERIOD) drive(1'b1, pat(win_q.size()), 1'b1);

    // Enable gating at phase 3
    run_until_k(3, 1'b1);
    repeat (5) drive(1'b0, pat(win_q.size()), 1'b1);
    repeat (2 * PERIOD) drive(1'b1, pat(win_q.size()), 1'b1);

    // Reset mid-operation at phase 5 with a full duty on ch0
    run_until_k(0, 1'b0);
    repeat (PERIOD) drive(1'b1, pat(win_q.size()), 1'b0);
    repeat (5) drive(1'b1, pat(win_q.size()), 1'b0);
    @(posedge clk);
    #3;
    chk("pre_reset_duty0", 64'(duty[CW-1:0]), 64'(PERIOD));
    rst_n = 1'b0;
    #1;
    chk("async_reset_duty", 64'(duty), 64'd0);
    chk("async_reset_pwm", 64'(pwm_out), 64'd0);
    chk("async_reset_dv", 64'(duty_valid), 64'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_now(1'b1, pat(0), 1'b0);
    repeat (2 * PERIOD) drive(1'b1, pat(win_q.size()), 1'b0);

    // Channel isolation: 25% density on ch0, random on the others,
    // random enable gaps and occasional alignment changes
    m = 1'b0;
    repeat (20 * PERIOD + 20) begin
      logic [NCH-1:0] bs;
      logic           e;
      bs    = NCH'($urandom_range(0, (1 << NCH) - 1));
      bs[0] = (win_q.size() % 4 == 0);
      e     = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) m = ~m;
      drive(e, bs, m);
    end
    run_until_k(0, m);
    repeat (PERIOD) drive(1'b1, '0, m);

    // Drain
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #2;
    chk("cyc_q_drained", 64'(cyc_q.size()), 64'd0);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_pwm_multi.md
Name: sd_pwm_multi

Overview:
Multi-channel sigma-delta bitstream to PWM re-modulator. Each of NCH 1-bit sigma-delta streams is density-counted over a shared window of PERIOD enabled cycles. The count is latched as that channel's duty for the next window and regenerated as a PWM waveform with selectable alignment. The block sits downstream of the sigma-delta modulators. It also exports latched duty words plus a window strobe for monitoring and logging.

Parameters:
NCH, 4, number of independent channels (>=1)
PERIOD, 60, window length in enabled clk cycles (>=2); also the PWM period
CW (localparam), $clog2(PERIOD+1), width of the sum and duty words; holds 0..PERIOD

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  count enable; low freezes window state
align_mode  input  1  0 = left-aligned PWM, 1 = right-aligned PWM; sampled at window boundary
sd_bs  input  NCH  sigma-delta bitstreams, bit i = channel i
pwm_out  output  NCH  registered PWM outputs, bit i = channel i
duty  output  NCH*CW  latched duty words, channel i at [i*CW +: CW]
duty_valid  output  1  one-cycle pulse: duty updated on this edge

Behaviour:
- Reset (rst_n low, asynchronous): phase counter=0, all sums=0, all duty=0, latched mode=0, pwm_out=0, duty_valid=0. Release is synchronous to the next clk edge. The first window starts at phase 0.
- Shared phase counter counts 0..PERIOD-1 when en=1 and wraps to 0 after PERIOD-1. There is one counter for all channels, so windows are phase-aligned across channels.
- Per channel, on each enabled edge:
  - phase != PERIOD-1: sum <= sum + sd_bs[i].
  - phase == PERIOD-1 (boundary): duty[i] <= sum + sd_bs[i]. The sample taken on this cycle is included. sum <= 0.
- Arithmetic: sum never exceeds PERIOD, so no overflow or saturation logic. duty range is 0..PERIOD inclusive.
- Boundary edge: latched mode <= align_mode, and duty_valid <= 1. On every other edge duty_valid <= 0.
  - Changing align_mode mid-window has no effect until the next boundary.
- PWM compare is registered, one cycle latency. It uses the pre-edge phase value, pre-edge duty and pre-edge latched mode.
  - Left (mode 0): pwm_out[i] <= (phase < duty[i]).
  - Right (mode 1): pwm_out[i] <= (phase >= PERIOD - duty[i]).
  - duty=0 gives a constant 0 output; duty=PERIOD gives a constant 1 output; high time per window equals duty exactly in both modes.
- Duty latched at a boundary drives the PWM over the following window. PWM therefore trails the measured window by one window plus one cycle.
- en=0:
  - phase counter, sums, duty and latched mode hold.
  - pwm_out <= 0 and duty_valid <= 0.
  - Samples on disabled cycles are not counted.
  - Re-asserting en resumes the interrupted window at the held phase; the window still spans exactly PERIOD enabled samples.
- Boundary with en=0: no latch, no strobe; the boundary occurs on the next enabled cycle at phase PERIOD-1.
- Reset mid-window: discards partial sums and latched duty; outputs go to 0 immediately (asynchronously).
- Channels are fully independent apart from the shared phase counter, mode and strobe. Any sd_bs pattern on one channel must not affect another.

Test Plan:
- Reset/idle: PERIOD=8, NCH=4, en=1, sd_bs=0 for 32 cycles -> duty all 0, pwm_out all 0, duty_valid pulses every 8 cycles, first pulse 8 edges after reset release.
- Extremes and density (mode 0):
  - Stimulus: ch0 sd_bs=1 constant; ch1 alternates 1,0 from phase 0; ch2 = 1 on phase 7 only.
  - First strobe: duty0=8, duty1=4, duty2=1.
  - Next window: pwm0 high 8/8 cycles; pwm1 high on the cycles following phases 0-3; pwm2 high only after phase 0.
- Right alignment: same stimulus, align_mode=1 set mid-window -> mode applies from the next boundary; pwm1 high after phases 4-7 and pwm2 high only after phase 7; high counts unchanged.
- Enable gating: drop en for 5 cycles at phase 3 while ch0=1 continues:
  - pwm_out=0 and no strobe during the gap.
  - After resume, the strobe arrives 5 cycles late and duty0=8, not 13.
- Reset mid-operation: assert rst_n low at phase 5 with duty0=8 -> duty, pwm_out, duty_valid go 0 without a clock edge; after release, the first strobe comes 8 enabled edges later with a fresh count.
- Channel isolation: random sd_bs on ch3 with fixed 25% density on ch0 over 20 windows -> duty0=2 every window; ch3 duty matches a reference count of ones per window.
